// File: rtl/dbg_run_ctrl.sv
// Run-control sequencer between the serial debug unit and the pipelined CPU:
// ownership of RF/memories, step/run/breakpoint control and program-load strobes.
module dbg_run_ctrl #(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      npc,
  output logic             cpu_en,
  output logic             debug,
  output logic             we_im,
  output logic             we_dm,
  output logic             halted,
  output logic             bp_hit,
  output logic             cmd_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam logic [2:0] OP_STEP   = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_HALT   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;
  localparam logic [2:0] OP_WR_IM  = 3'd6;
  localparam logic [2:0] OP_WR_DM  = 3'd7;
  localparam logic [2:0] OP_NOP    = 3'd0;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_rem_q, step_rem_d;
  logic              bp_en_q, bp_en_d;
  logic [31:0]       bp_addr_q, bp_addr_d;
  logic              bp_hit_q, bp_hit_d;
  logic              cmd_err_q, cmd_err_d;
  logic              we_im_q, we_im_d;
  logic              we_dm_q, we_dm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_en_q, cpu_en_d;
  logic              debug_q, debug_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_acc;
  logic              advance;
  logic              bp_match;

  // Next-state, bookkeeping and registered-output decode
  always_comb begin
    state_d     = state_q;
    step_rem_d  = step_rem_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    bp_hit_d    = bp_hit_q;
    cmd_err_d   = 1'b0;
    we_im_d     = 1'b0;
    we_dm_d     = 1'b0;
    cnt_d       = cnt_q;
    cmd_acc     = cmd_valid && cmd_ready_q;
    advance     = (state_q == ST_STEP) || (state_q == ST_RUN);
    bp_match    = advance && bp_en_q && (npc == bp_addr_q);

    if (advance) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_HALT: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_STEP: begin
              step_rem_d = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];
              state_d    = ST_STEP;
              bp_hit_d   = 1'b0;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              bp_hit_d = 1'b0;
            end
            OP_SET_BP: begin
              bp_addr_d = cmd_arg;
              bp_en_d   = 1'b1;
            end
            OP_CLR_BP: bp_en_d = 1'b0;
            OP_WR_IM: begin
              state_d = ST_WR;
              we_im_d = 1'b1;
            end
            OP_WR_DM: begin
              state_d = ST_WR;
              we_dm_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        step_rem_d = step_rem_q - STEP_W'(1);
        if (step_rem_q <= STEP_W'(1)) state_d = ST_HALT;
      end
      ST_RUN: begin
        if (cmd_acc) begin
          if (cmd_op == OP_HALT)     state_d   = ST_HALT;
          else if (cmd_op != OP_NOP) cmd_err_d = 1'b1;
        end
      end
      ST_WR: state_d = ST_HALT;
    endcase

    // Breakpoint wins over every other transition out of STEP/RUN
    if (bp_match) begin
      state_d  = ST_HALT;
      bp_hit_d = 1'b1;
    end

    cpu_en_d    = (state_d == ST_STEP) || (state_d == ST_RUN);
    debug_d     = (state_d == ST_HALT) || (state_d == ST_WR);
    cmd_ready_d = (state_d == ST_HALT) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_HALT;
      step_rem_q  <= '0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      bp_hit_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      we_im_q     <= 1'b0;
      we_dm_q     <= 1'b0;
      cnt_q       <= '0;
      cpu_en_q    <= 1'b0;
      debug_q     <= 1'b1;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_rem_q  <= step_rem_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      bp_hit_q    <= bp_hit_d;
      cmd_err_q   <= cmd_err_d;
      we_im_q     <= we_im_d;
      we_dm_q     <= we_dm_d;
      cnt_q       <= cnt_d;
      cpu_en_q    <= cpu_en_d;
      debug_q     <= debug_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cpu_en    = cpu_en_q;
  assign debug     = debug_q;
  assign halted    = debug_q;
  assign we_im     = we_im_q;
  assign we_dm     = we_dm_q;
  assign bp_hit    = bp_hit_q;
  assign cmd_err   = cmd_err_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed scoreboard bench for dbg_run_ctrl; a narrow-counter copy shares
// the stimulus so the cycle counter wrap is reachable in a short run.
module tb_dbg_run_ctrl;

  typedef struct packed {
    logic        cpu_en;
    logic        debug;
    logic        halted;
    logic        cmd_ready;
    logic        we_im;
    logic        we_dm;
    logic        bp_hit;
    logic        cmd_err;
    logic [31:0] cnt;
  } snap_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] npc;

  logic        cmd_ready, cpu_en, debug, we_im, we_dm, halted, bp_hit, cmd_err;
  logic [31:0] cycle_cnt;
  logic        cmd_ready_w, cpu_en_w, debug_w, we_im_w, we_dm_w, halted_w, bp_hit_w, cmd_err_w;
  logic [3:0]  cycle_cnt_w;

  snap_t exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(.STEP_W(16), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .npc(npc), .cpu_en(cpu_en),
    .debug(debug), .we_im(we_im), .we_dm(we_dm), .halted(halted),
    .bp_hit(bp_hit), .cmd_err(cmd_err), .cycle_cnt(cycle_cnt)
  );

  dbg_run_ctrl #(.STEP_W(16), .CNT_W(4)) dut_w (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .npc(npc), .cpu_en(cpu_en_w),
    .debug(debug_w), .we_im(we_im_w), .we_dm(we_dm_w), .halted(halted_w),
    .bp_hit(bp_hit_w), .cmd_err(cmd_err_w), .cycle_cnt(cycle_cnt_w)
  );

  localparam int H = 0, S = 1, R = 2, W = 3;
  localparam logic [2:0] NOP = 3'd0, STEP = 3'd1, RUN = 3'd2, HALT = 3'd3,
                         SETBP = 3'd4, CLRBP = 3'd5, WRIM = 3'd6, WRDM = 3'd7;

  function automatic snap_t mk(input int st, input logic wim, input logic wdm,
                               input logic bph, input logic err, input logic [31:0] cnt);
    snap_t e;
    e.cpu_en    = (st == S) || (st == R);
    e.debug     = (st == H) || (st == W);
    e.halted    = (st == H) || (st == W);
    e.cmd_ready = (st == H) || (st == R);
    e.we_im     = wim;
    e.we_dm     = wdm;
    e.bp_hit    = bph;
    e.cmd_err   = err;
    e.cnt       = cnt;
    return e;
  endfunction

  // One cycle: drive this cycle's inputs and queue the outputs expected in it
  task automatic cyc(input string nm, input logic v, input logic [2:0] op,
                     input logic [31:0] arg, input logic [31:0] pc, input snap_t e);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    npc       = pc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every observed cycle with a queued expectation is compared
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {cpu_en, debug, halted, cmd_ready, we_im, we_dm, bp_hit, cmd_err, cycle_cnt};
      n_chk++;
      if (a === e && cycle_cnt_w === e.cnt[3:0]) n_pass++;
      else $display("FAIL %s: got en/dbg/hlt/rdy/wim/wdm/bph/err=%b cnt=%h cnt4=%h, want %b cnt=%h cnt4=%h",
                    nm, a[39:32], a.cnt, cycle_cnt_w, e[39:32], e.cnt, e.cnt[3:0]);
    end
  end

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0; npc = '0;
    cyc("rst_hold",  0, NOP,   0,          32'h0,    mk(H,0,0,0,0,0));
    rstn = 1'b1;
    cyc("idle",      0, NOP,   0,          32'h0,    mk(H,0,0,0,0,0));
    cyc("step3_acc", 1, STEP,  3,          32'h0,    mk(H,0,0,0,0,0));
    cyc("step3_c1",  0, NOP,   0,          32'h4,    mk(S,0,0,0,0,0));
    cyc("step3_c2",  1, RUN,   0,          32'h8,    mk(S,0,0,0,0,1));
    cyc("step3_c3",  0, NOP,   0,          32'hC,    mk(S,0,0,0,0,2));
    cyc("step0_acc", 1, STEP,  0,          32'h10,   mk(H,0,0,0,0,3));
    cyc("step0_c1",  0, NOP,   0,          32'h14,   mk(S,0,0,0,0,3));
    cyc("setbp",     1, SETBP, 32'h3010,   32'h18,   mk(H,0,0,0,0,4));
    cyc("run_acc",   1, RUN,   0,          32'h3000, mk(H,0,0,0,0,4));
    cyc("run_c1",    0, NOP,   0,          32'h3004, mk(R,0,0,0,0,4));
    cyc("run_c2",    0, NOP,   0,          32'h3008, mk(R,0,0,0,0,5));
    cyc("run_c3",    0, NOP,   0,          32'h300C, mk(R,0,0,0,0,6));
    cyc("run_bp",    0, NOP,   0,          32'h3010, mk(R,0,0,0,0,7));
    cyc("bp_halt",   1, STEP,  1,          32'h3010, mk(H,0,0,1,0,8));
    cyc("resume",    0, NOP,   0,          32'h3014, mk(S,0,0,0,0,8));
    cyc("clrbp",     1, CLRBP, 0,          32'h3018, mk(H,0,0,0,0,9));
    cyc("run2_acc",  1, RUN,   0,          32'h3010, mk(H,0,0,0,0,9));
    cyc("run_wrim",  1, WRIM,  0,          32'h3010, mk(R,0,0,0,0,9));
    cyc("run_err",   1, NOP,   0,          32'h3014, mk(R,0,0,0,1,10));
    cyc("run_halt",  1, HALT,  0,          32'h3018, mk(R,0,0,0,0,11));
    cyc("halted",    1, WRIM,  0,          32'h301C, mk(H,0,0,0,0,12));
    cyc("wr_im",     1, WRDM,  0,          32'h301C, mk(W,1,0,0,0,12));
    cyc("wr_back",   1, WRDM,  0,          32'h301C, mk(H,0,0,0,0,12));
    cyc("wr_dm",     0, NOP,   0,          32'h301C, mk(W,0,1,0,0,12));
    cyc("setbp2",    1, SETBP, 32'h4000,   32'h301C, mk(H,0,0,0,0,12));
    cyc("step2_acc", 1, STEP,  2,          32'h3FF8, mk(H,0,0,0,0,12));
    cyc("step2_c1",  0, NOP,   0,          32'h3FFC, mk(S,0,0,0,0,12));
    cyc("step2_bp",  0, NOP,   0,          32'h4000, mk(S,0,0,0,0,13));
    cyc("bp_last",   1, RUN,   0,          32'h4000, mk(H,0,0,1,0,14));
    cyc("run3_c1",   0, NOP,   0,          32'h4004, mk(R,0,0,0,0,14));
    cyc("run3_c2",   0, NOP,   0,          32'h4008, mk(R,0,0,0,0,15));
    cyc("cnt_wrap4", 1, HALT,  0,          32'h400C, mk(R,0,0,0,0,16));
    cyc("halt3",     1, RUN,   0,          32'h4010, mk(H,0,0,0,0,17));
    cyc("run4_c1",   0, NOP,   0,          32'h4014, mk(R,0,0,0,0,17));
    // Reset asserted mid-RUN: outputs must drop within the same cycle
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_q.push_back(mk(H,0,0,0,0,0)); name_q.push_back("rst_run");
    @(posedge clk); #1;
    rstn = 1'b1;
    cmd_valid = 1'b1; cmd_op = STEP; cmd_arg = 32'd5;
    exp_q.push_back(mk(H,0,0,0,0,0)); name_q.push_back("rst_rel");
    cyc("step5_c1",  0, NOP,   0,          32'h0,    mk(S,0,0,0,0,0));
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_q.push_back(mk(H,0,0,0,0,0)); name_q.push_back("rst_step");
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc("post_rst",  0, NOP,   0,          32'h0,    mk(H,0,0,0,0,0));
    cyc("post_rst2", 0, NOP,   0,          32'h0,    mk(H,0,0,0,0,0));
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
